// File: rtl/fetch_unit_if.sv
// fetch_unit_if
//   Bundles the instruction-memory request channel, the core-facing
//   instruction channel, the redirect inputs and the retired-fetch counter.
//   master : fetch unit side (drives requests, instruction, counter)
//   slave  : memory + core side (drives ack/rdata, ready, redirect)
//
//   imem_req / imem_addr       request held until imem_ack
//   imem_ack / imem_rdata      memory response
//   instr / instr_pc / instr_valid / instr_ready   core handshake
//   branch_taken / branch_off / jump / jump_tgt    redirect, used on consume
//   fetch_count                instructions consumed since reset
interface fetch_unit_if #(
   parameter int CNT_W = 32
) ();
   logic              imem_req;
   logic [31:0]       imem_addr;
   logic              imem_ack;
   logic [31:0]       imem_rdata;

   logic [31:0]       instr;
   logic [31:0]       instr_pc;
   logic              instr_valid;
   logic              instr_ready;

   logic              branch_taken;
   logic [15:0]       branch_off;
   logic              jump;
   logic [25:0]       jump_tgt;

   logic [CNT_W-1:0]  fetch_count;

   modport master (
      output imem_req, imem_addr,
      input  imem_ack, imem_rdata,
      output instr, instr_pc, instr_valid,
      input  instr_ready,
      input  branch_taken, branch_off, jump, jump_tgt,
      output fetch_count
   );

   modport slave (
      input  imem_req, imem_addr,
      output imem_ack, imem_rdata,
      input  instr, instr_pc, instr_valid,
      output instr_ready,
      output branch_taken, branch_off, jump, jump_tgt,
      input  fetch_count
   );
endinterface

// File: rtl/fetch_unit.sv
// fetch_unit
//   Instruction fetch stage in front of a single-cycle core. Owns the PC,
//   requests one word at a time from instruction memory (req/ack), presents
//   it to the core (valid/ready) and picks the next PC from the redirect
//   inputs at the moment the core consumes the instruction.
//
//   clk  : system clock, rising edge
//   rst  : asynchronous active-high reset
//   bus  : fetch_unit_if.master (memory channel, core channel, redirect,
//          retired-fetch counter)
//
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   ST_BOOT  | one idle cycle after reset, no request
//   ST_FETCH | imem_req high at pc, waiting for imem_ack
//   ST_VALID | instruction held for the core, waiting for instr_ready
module fetch_unit #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter int          CNT_W    = 32
) (
   input  logic             clk,
   input  logic             rst,
   fetch_unit_if.master     bus
);

   typedef enum logic [1:0] {
      ST_BOOT  = 2'd0,
      ST_FETCH = 2'd1,
      ST_VALID = 2'd2
   } state_t;

   state_t            state_q, state_d;
   logic [31:0]       pc_q, pc_d;
   logic [31:0]       instr_q, instr_d;
   logic [31:0]       instr_pc_q, instr_pc_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;

   logic              fetch_done;
   logic              consume;
   logic [31:0]       pc4;
   logic [31:0]       br_off;
   logic [31:0]       next_pc;

   assign fetch_done = (state_q == ST_FETCH) && bus.imem_ack;
   assign consume    = (state_q == ST_VALID) && bus.instr_ready;

   // Redirect is computed from the held instr_pc, not pc, so it is
   // independent of anything the memory side does while the core decides.
   assign pc4    = instr_pc_q + 32'd4;
   assign br_off = {{14{bus.branch_off[15]}}, bus.branch_off, 2'b00};

   always_comb begin
      next_pc = pc4;
      if (bus.jump) begin
         next_pc = {pc4[31:28], bus.jump_tgt, 2'b00};
      end else if (bus.branch_taken) begin
         next_pc = pc4 + br_off;
      end
   end

   // state register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_BOOT;
      end else begin
         state_q <= state_d;
      end
   end

   // next-state logic
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_BOOT:  state_d = ST_FETCH;
         ST_FETCH: if (bus.imem_ack)    state_d = ST_VALID;
         ST_VALID: if (bus.instr_ready) state_d = ST_FETCH;
         default:  state_d = ST_BOOT;
      endcase
   end

   // datapath next values
   always_comb begin
      pc_d       = pc_q;
      instr_d    = instr_q;
      instr_pc_d = instr_pc_q;
      cnt_d      = cnt_q;
      if (fetch_done) begin
         instr_d    = bus.imem_rdata;
         instr_pc_d = pc_q;
      end
      if (consume) begin
         pc_d  = next_pc;
         cnt_d = cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pc_q       <= RESET_PC;
         instr_q    <= 32'd0;
         instr_pc_q <= 32'd0;
         cnt_q      <= '0;
      end else begin
         pc_q       <= pc_d;
         instr_q    <= instr_d;
         instr_pc_q <= instr_pc_d;
         cnt_q      <= cnt_d;
      end
   end

   // outputs; req/valid decode straight from state so reset drops them at once
   always_comb begin
      bus.imem_req    = 1'b0;
      bus.instr_valid = 1'b0;
      case (state_q)
         ST_FETCH: bus.imem_req    = 1'b1;
         ST_VALID: bus.instr_valid = 1'b1;
         default:  ;
      endcase
      bus.imem_addr   = pc_q;
      bus.instr       = instr_q;
      bus.instr_pc    = instr_pc_q;
      bus.fetch_count = cnt_q;
   end

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;
   localparam logic [31:0] RESET_PC = 32'h0000_0000;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   fetch_unit_if #(.CNT_W(32)) bus ();

   fetch_unit #(.RESET_PC(RESET_PC), .CNT_W(32)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int total = 0;
   int bad   = 0;
   logic [31:0] mpc;
   logic [31:0] mcnt;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // reference next-PC from the architectural rule
   function automatic logic [31:0] ref_next(input logic [31:0] ipc, input logic j,
                                            input logic [25:0] tgt, input logic bt,
                                            input logic [15:0] off);
      logic [31:0] seq;
      int soff;
      seq = ipc + 32'd4;
      if (j) return (seq & 32'hF000_0000) | ({6'd0, tgt} * 4);
      if (bt) begin
         soff = int'($signed(off));
         return seq + 32'(soff * 4);
      end
      return seq;
   endfunction

   task automatic scramble_redirect();
      bus.branch_taken = 1'($urandom);
      bus.branch_off   = 16'($urandom);
      bus.jump         = 1'($urandom);
      bus.jump_tgt     = 26'($urandom);
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      bus.imem_ack = 1'b0;
      bus.instr_ready = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      mpc  = RESET_PC;
      mcnt = 32'd0;
   endtask

   // Runs one fetch/consume transaction and reports what it observed.
   task automatic run_txn(input int wait_n, input int ready_n, input logic [31:0] word,
                          input logic j, input logic [25:0] tgt, input logic bt,
                          input logic [15:0] off,
                          output logic [31:0] addr_o, output bit stable_o,
                          output bit valid_o, output logic [31:0] instr_o,
                          output logic [31:0] ipc_o, output bit to_o);
      int n;
      logic [31:0] c;
      n = 0;
      to_o = 0;
      stable_o = 1;
      valid_o = 0;
      addr_o = 'x;
      instr_o = 'x;
      ipc_o = 'x;
      bus.imem_ack = 1'b0;
      while (bus.imem_req !== 1'b1) begin
         if (n >= 20) begin
            to_o = 1;
            return;
         end
         bus.instr_ready = 1'($urandom);
         @(negedge clk);
         n++;
      end
      addr_o = bus.imem_addr;
      for (int i = 0; i < wait_n; i++) begin
         bus.imem_ack    = 1'b0;
         bus.imem_rdata  = $urandom;
         bus.instr_ready = 1'($urandom);
         scramble_redirect();
         @(negedge clk);
         if (bus.imem_req !== 1'b1 || bus.imem_addr !== addr_o || bus.instr_valid !== 1'b0)
            stable_o = 0;
      end
      bus.imem_ack    = 1'b1;
      bus.imem_rdata  = word;
      bus.instr_ready = 1'($urandom);
      @(negedge clk);
      valid_o = (bus.instr_valid === 1'b1) && (bus.imem_req === 1'b0);
      instr_o = bus.instr;
      ipc_o   = bus.instr_pc;
      c       = bus.fetch_count;
      for (int i = 0; i < ready_n; i++) begin
         bus.instr_ready = 1'b0;
         bus.imem_ack    = 1'($urandom);
         bus.imem_rdata  = $urandom;
         scramble_redirect();
         @(negedge clk);
         if (bus.instr_valid !== 1'b1 || bus.imem_req !== 1'b0 || bus.instr !== instr_o ||
             bus.instr_pc !== ipc_o || bus.fetch_count !== c)
            stable_o = 0;
      end
      bus.instr_ready  = 1'b1;
      bus.imem_ack     = 1'($urandom);
      bus.jump         = j;
      bus.jump_tgt     = tgt;
      bus.branch_taken = bt;
      bus.branch_off   = off;
      @(negedge clk);
      bus.instr_ready = 1'b0;
      bus.imem_ack    = 1'b0;
      scramble_redirect();
   endtask

   task automatic test_reset();
      @(negedge clk);
      @(negedge clk);
      total++;
      if (bus.imem_req !== 1'b0 || bus.instr_valid !== 1'b0 || bus.imem_addr !== RESET_PC ||
          bus.instr !== 32'd0 || bus.instr_pc !== 32'd0 || bus.fetch_count !== 32'd0) begin
         bad++;
         $display("FAIL reset_state: req=%b valid=%b addr=%h instr=%h ipc=%h cnt=%0d expected 0/0/%h/0/0/0",
                  bus.imem_req, bus.instr_valid, bus.imem_addr, bus.instr, bus.instr_pc,
                  bus.fetch_count, RESET_PC);
      end
      rst = 1'b0;
      mpc = RESET_PC;
      mcnt = 32'd0;
      #1;
      total++;
      if (bus.imem_req !== 1'b0) begin
         bad++;
         $display("FAIL boot_no_req: req=%b expected 0", bus.imem_req);
      end
      @(negedge clk);
      total++;
      if (bus.imem_req !== 1'b1 || bus.imem_addr !== RESET_PC) begin
         bad++;
         $display("FAIL first_req: req=%b addr=%h expected 1/%h", bus.imem_req, bus.imem_addr, RESET_PC);
      end
   endtask

   task automatic test_sequential();
      logic [31:0] a, ins, ipc, w;
      bit st, v, to;
      for (int k = 0; k < 3; k++) begin
         w = $urandom;
         run_txn(0, 0, w, 1'b0, 26'd0, 1'b0, 16'd0, a, st, v, ins, ipc, to);
         total++;
         if (to || a !== mpc || !v || ins !== w || ipc !== mpc) begin
            bad++;
            $display("FAIL seq_txn%0d: to=%b addr=%h valid=%b instr=%h ipc=%h expected addr=%h instr=%h",
                     k, to, a, v, ins, ipc, mpc, w);
         end
         mpc = ref_next(mpc, 1'b0, 26'd0, 1'b0, 16'd0);
         mcnt++;
      end
      total++;
      if (bus.fetch_count !== mcnt || bus.imem_addr !== mpc || bus.instr_valid !== 1'b0) begin
         bad++;
         $display("FAIL seq_count: cnt=%0d addr=%h valid=%b expected %0d/%h/0",
                  bus.fetch_count, bus.imem_addr, bus.instr_valid, mcnt, mpc);
      end
   endtask

   task automatic test_ack_wait();
      logic [31:0] a, ins, ipc, w;
      bit st, v, to;
      do_reset();
      for (int k = 0; k < 2; k++) begin
         run_txn(0, 0, $urandom, 1'b0, 26'd0, 1'b0, 16'd0, a, st, v, ins, ipc, to);
         mpc = ref_next(mpc, 1'b0, 26'd0, 1'b0, 16'd0);
         mcnt++;
      end
      w = 32'hDEAD_BEEF;
      run_txn(3, 0, w, 1'b0, 26'd0, 1'b0, 16'd0, a, st, v, ins, ipc, to);
      total++;
      if (to || a !== 32'h8 || !st || !v || ins !== w || ipc !== 32'h8) begin
         bad++;
         $display("FAIL ack_wait: to=%b addr=%h stable=%b valid=%b instr=%h ipc=%h expected 8/1/1/%h/8",
                  to, a, st, v, ins, ipc, w);
      end
      mpc = ref_next(mpc, 1'b0, 26'd0, 1'b0, 16'd0);
      mcnt++;
   endtask

   task automatic test_ready_stall();
      logic [31:0] a, ins, ipc, w;
      bit st, v, to;
      w = $urandom;
      run_txn(0, 5, w, 1'b0, 26'd0, 1'b0, 16'd0, a, st, v, ins, ipc, to);
      mpc = ref_next(mpc, 1'b0, 26'd0, 1'b0, 16'd0);
      mcnt++;
      total++;
      if (to || !st || !v || ins !== w) begin
         bad++;
         $display("FAIL ready_stall: to=%b stable=%b valid=%b instr=%h expected 0/1/1/%h", to, st, v, ins, w);
      end
      total++;
      if (bus.fetch_count !== mcnt || bus.imem_addr !== mpc) begin
         bad++;
         $display("FAIL stall_count: cnt=%0d addr=%h expected %0d/%h", bus.fetch_count, bus.imem_addr, mcnt, mpc);
      end
   endtask

   task automatic test_branch();
      logic [31:0] a, ins, ipc;
      bit st, v, to;
      logic [15:0] offs [2];
      logic [31:0] exp [2];
      offs[0] = 16'hFFFC; exp[0] = 32'h0000_0004;
      offs[1] = 16'h0003; exp[1] = 32'h0000_0020;
      do_reset();
      for (int k = 0; k < 2; k++) begin
         run_txn(0, 0, $urandom, 1'b1, 26'h4, 1'b0, 16'd0, a, st, v, ins, ipc, to);
         mpc = ref_next(mpc, 1'b1, 26'h4, 1'b0, 16'd0);
         mcnt++;
         run_txn(0, 0, $urandom, 1'b0, 26'd0, 1'b1, offs[k], a, st, v, ins, ipc, to);
         total++;
         if (to || ipc !== 32'h10 || bus.imem_addr !== exp[k] || bus.imem_req !== 1'b1) begin
            bad++;
            $display("FAIL branch%0d: to=%b ipc=%h next_addr=%h req=%b expected ipc=10 addr=%h",
                     k, to, ipc, bus.imem_addr, bus.imem_req, exp[k]);
         end
         mpc = ref_next(mpc, 1'b0, 26'd0, 1'b1, offs[k]);
         mcnt++;
      end
      // backward branch from 0 lands at the top of memory, then sequential wraps to 0
      do_reset();
      run_txn(0, 0, $urandom, 1'b0, 26'd0, 1'b1, 16'hFFFE, a, st, v, ins, ipc, to);
      total++;
      if (to || bus.imem_addr !== 32'hFFFF_FFFC) begin
         bad++;
         $display("FAIL branch_back: to=%b addr=%h expected fffffffc", to, bus.imem_addr);
      end
      run_txn(0, 0, $urandom, 1'b0, 26'd0, 1'b0, 16'd0, a, st, v, ins, ipc, to);
      total++;
      if (to || ipc !== 32'hFFFF_FFFC || bus.imem_addr !== 32'h0) begin
         bad++;
         $display("FAIL pc_wrap: to=%b ipc=%h addr=%h expected fffffffc/0", to, ipc, bus.imem_addr);
      end
      mpc = 32'h0;
      mcnt = 32'd2;
   endtask

   task automatic test_jump();
      logic [31:0] a, ins, ipc;
      bit st, v, to;
      int tos;
      tos = 0;
      do_reset();
      // walk the PC up to 0x4000_0000 with maximal forward branches
      for (int k = 0; k < 8192; k++) begin
         run_txn(0, 0, $urandom, 1'b0, 26'd0, 1'b1, 16'h7FFF, a, st, v, ins, ipc, to);
         if (to) tos++;
         mpc = ref_next(mpc, 1'b0, 26'd0, 1'b1, 16'h7FFF);
         mcnt++;
      end
      total++;
      if (tos != 0 || bus.imem_addr !== 32'h4000_0000 || mpc !== 32'h4000_0000 || bus.fetch_count !== mcnt) begin
         bad++;
         $display("FAIL branch_walk: timeouts=%0d addr=%h cnt=%0d expected 0/40000000/%0d",
                  tos, bus.imem_addr, bus.fetch_count, mcnt);
      end
      run_txn(0, 0, $urandom, 1'b1, 26'h0000100, 1'b1, 16'($urandom), a, st, v, ins, ipc, to);
      mcnt++;
      total++;
      if (to || ipc !== 32'h4000_0000 || bus.imem_addr !== 32'h4000_0400) begin
         bad++;
         $display("FAIL jump_prio: to=%b ipc=%h addr=%h expected 40000000/40000400", to, ipc, bus.imem_addr);
      end
      mpc = 32'h4000_0400;
   endtask

   task automatic test_random();
      logic [31:0] a, ins, ipc, w;
      bit st, v, to;
      logic j, bt;
      logic [25:0] tgt;
      logic [15:0] off;
      int errs;
      errs = 0;
      for (int k = 0; k < 200; k++) begin
         w   = $urandom;
         j   = ($urandom_range(0, 3) == 0);
         bt  = 1'($urandom);
         tgt = 26'($urandom);
         off = 16'($urandom);
         run_txn($urandom_range(0, 3), $urandom_range(0, 3), w, j, tgt, bt, off, a, st, v, ins, ipc, to);
         total++;
         if (to || a !== mpc || !st || !v || ins !== w || ipc !== mpc) begin
            bad++;
            errs++;
            if (errs < 5)
               $display("FAIL rand_txn%0d: to=%b addr=%h stable=%b valid=%b instr=%h ipc=%h expected addr=%h instr=%h",
                        k, to, a, st, v, ins, ipc, mpc, w);
         end
         mpc = ref_next(mpc, j, tgt, bt, off);
         mcnt++;
      end
      total++;
      if (bus.fetch_count !== mcnt || bus.imem_addr !== mpc) begin
         bad++;
         $display("FAIL rand_final: cnt=%0d addr=%h expected %0d/%h", bus.fetch_count, bus.imem_addr, mcnt, mpc);
      end
   endtask

   task automatic test_reset_mid_op();
      int n;
      // reset while in FETCH with an ack in the same cycle
      n = 0;
      while (bus.imem_req !== 1'b1 && n < 20) begin
         @(negedge clk);
         n++;
      end
      bus.imem_ack   = 1'b1;
      bus.imem_rdata = 32'hCAFE_F00D;
      rst = 1'b1;
      #1;
      total++;
      if (bus.imem_req !== 1'b0 || bus.instr_valid !== 1'b0) begin
         bad++;
         $display("FAIL rst_fetch_now: req=%b valid=%b expected 0/0", bus.imem_req, bus.instr_valid);
      end
      @(negedge clk);
      total++;
      if (bus.instr !== 32'd0 || bus.instr_pc !== 32'd0 || bus.instr_valid !== 1'b0 || bus.fetch_count !== 32'd0) begin
         bad++;
         $display("FAIL rst_ack_drop: instr=%h ipc=%h valid=%b cnt=%0d expected 0/0/0/0",
                  bus.instr, bus.instr_pc, bus.instr_valid, bus.fetch_count);
      end
      bus.imem_ack = 1'b0;
      rst = 1'b0;
      @(negedge clk);
      total++;
      if (bus.imem_req !== 1'b1 || bus.imem_addr !== RESET_PC || bus.fetch_count !== 32'd0) begin
         bad++;
         $display("FAIL rst_restart: req=%b addr=%h cnt=%0d expected 1/%h/0",
                  bus.imem_req, bus.imem_addr, bus.fetch_count, RESET_PC);
      end
      // reset while VALID with ready high: not counted
      bus.imem_ack = 1'b1;
      bus.imem_rdata = $urandom;
      @(negedge clk);
      bus.imem_ack = 1'b0;
      bus.instr_ready = 1'b1;
      rst = 1'b1;
      #1;
      total++;
      if (bus.instr_valid !== 1'b0) begin
         bad++;
         $display("FAIL rst_valid_now: valid=%b expected 0", bus.instr_valid);
      end
      @(negedge clk);
      total++;
      if (bus.fetch_count !== 32'd0 || bus.imem_addr !== RESET_PC) begin
         bad++;
         $display("FAIL rst_valid_count: cnt=%0d addr=%h expected 0/%h", bus.fetch_count, bus.imem_addr, RESET_PC);
      end
      bus.instr_ready = 1'b0;
      rst = 1'b0;
   endtask

   initial begin
      bus.imem_ack     = 1'b0;
      bus.imem_rdata   = 32'd0;
      bus.instr_ready  = 1'b0;
      bus.branch_taken = 1'b0;
      bus.branch_off   = 16'd0;
      bus.jump         = 1'b0;
      bus.jump_tgt     = 26'd0;
      mpc  = RESET_PC;
      mcnt = 32'd0;
      test_reset();
      test_sequential();
      test_ack_wait();
      test_ready_stall();
      test_branch();
      test_jump();
      test_random();
      test_reset_mid_op();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
